// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB3 register-file completer.
package apb_slave_pkg;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefMemDepth  = 64;

  // Every PRDATA bit takes this value on an error read.
  localparam bit ErrRdataFill = 1'b0;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between the bridge (master) and one completer (slave).
interface apb_slave_mem_if
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// Resettable flop-array memory: one synchronous write port, one combinational read port.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEM_DEPTH  = DefMemDepth,
  parameter int unsigned RF_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [RF_AW-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [RF_AW-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam logic [RF_AW:0] DepthCmp = (RF_AW + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && ({1'b0, i_waddr} < DepthCmp)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Guard keeps non-power-of-two depths from reading past the array.
  always_comb begin
    o_rdata = '0;
    if ({1'b0, i_raddr} < DepthCmp) begin
      o_rdata = r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer: latched setup phase, programmable wait states, regfile backing store.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned MEM_DEPTH   = DefMemDepth,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_slave_mem_if.slave apb
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned RfAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CntW-1:0]       WaitLoad = CntW'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0]   DepthCmp = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [CntW-1:0]       r_cnt;

  logic                  w_ready;
  logic                  w_err;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rf_rdata;
  logic [DATA_WIDTH-1:0] w_rd_val;

  always_comb begin
    w_ready  = (r_state == StAccess) && apb.PSEL && apb.PENABLE && (r_cnt == '0);
    w_err    = ({1'b0, r_addr} >= DepthCmp);
    w_we     = w_ready && r_wr && !w_err;
    w_rd_val = w_err ? {DATA_WIDTH{ErrRdataFill}} : w_rf_rdata;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (apb.PSEL && !apb.PENABLE) begin
            r_addr  <= apb.PADDR;
            r_wr    <= apb.PWRITE;
            r_wdata <= apb.PWDATA;
            r_cnt   <= WaitLoad;
            r_state <= StAccess;
          end
        end
        StAccess: begin
          if (!apb.PSEL) begin
            r_state <= StIdle;
          end else if (!apb.PENABLE) begin
            // A fresh setup phase mid-transfer restarts it with the new request.
            r_addr  <= apb.PADDR;
            r_wr    <= apb.PWRITE;
            r_wdata <= apb.PWDATA;
            r_cnt   <= WaitLoad;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (!r_wr) begin
              r_prdata <= w_rd_val;
            end
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .RF_AW      (RfAw)
  ) u_regfile (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_we    (w_we),
    .i_waddr (r_addr[RfAw-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (r_addr[RfAw-1:0]),
    .o_rdata (w_rf_rdata)
  );

  assign apb.PREADY  = w_ready;
  assign apb.PSLVERR = w_ready && w_err;
  assign apb.PRDATA  = (w_ready && !r_wr) ? w_rd_val : r_prdata;

endmodule
